// File: rtl/permute_round_sequencer.sv
// ---------------------------------------------------------------------------
// permute_round_sequencer
//
// Control-only sequencer for the Keccak-f permutation. For each of NUM_ROUNDS
// rounds it issues the five step units in order (theta, rho, pi, chi, iota),
// waits for each unit's done, and strobes write-back of that unit's result
// into the external state register. The round index feeds the iota round
// constant lookup.
//
// Optional feature (macro PERMUTE_STEP_TIMEOUT_EN):
//   A per-step watchdog. If a unit does not answer within TIMEOUT_CYCLES
//   cycles of WAIT, the sequencer parks in ERROR with error held high until
//   start (rerun) or abort (back to idle). Without the macro, error is tied
//   low and WAIT waits indefinitely.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   start      in   request a permutation (honoured in IDLE or ERROR only)
//   abort      in   synchronous cancel, returns to IDLE, highest priority
//   step_done  in   [4:0] per-unit done: 0 theta,1 rho,2 pi,3 chi,4 iota
//   step_start out  [4:0] one-hot single-cycle start to the active unit
//   step_sel   out  [2:0] write-back mux select, 0..4 = theta..iota
//   load_state out  capture external data_in into the state register
//   wb_en      out  write the selected unit's result (same cycle as done)
//   round_idx  out  [RND_W-1:0] current round
//   busy       out  high in LOAD, ISSUE and WAIT
//   done       out  one-cycle completion pulse
//   error      out  step watchdog fired (0 without the macro)
// ---------------------------------------------------------------------------
module permute_round_sequencer #(
  parameter int NUM_ROUNDS     = 24,
  parameter int RND_W          = 5,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [4:0]       step_done,
  output logic [4:0]       step_start,
  output logic [2:0]       step_sel,
  output logic             load_state,
  output logic             wb_en,
  output logic [RND_W-1:0] round_idx,
  output logic             busy,
  output logic             done,
  output logic             error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_FIN,
    S_ERROR
  } state_t;

  localparam logic [RND_W-1:0] LAST_ROUND = RND_W'(NUM_ROUNDS - 1);
  localparam logic [2:0]       PTR_IOTA   = 3'd4;

  if (NUM_ROUNDS < 1 || (1 << RND_W) < NUM_ROUNDS || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("permute_round_sequencer: invalid NUM_ROUNDS/RND_W/TIMEOUT_CYCLES");
  end

  state_t     state;
  logic [2:0] ptr;

`ifdef PERMUTE_STEP_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] wait_cnt;
`else
  assign error = 1'b0;
`endif

  function automatic logic [4:0] onehot(input logic [2:0] p);
    logic [4:0] v;
    v = 5'b00001 << p;
    return v;
  endfunction

  // Only the active unit's done is honoured, and only while waiting on it;
  // abort suppresses the write-back in the cycle it is seen.
  assign wb_en = (state == S_WAIT) && step_done[ptr] && !abort;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      ptr        <= 3'd0;
      step_start <= 5'd0;
      step_sel   <= 3'd0;
      load_state <= 1'b0;
      round_idx  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef PERMUTE_STEP_TIMEOUT_EN
      wait_cnt   <= '0;
      error      <= 1'b0;
`endif
    end else begin
      // Strobes default low; each is raised for exactly one cycle below.
      step_start <= 5'd0;
      load_state <= 1'b0;
      done       <= 1'b0;

      if (abort) begin
        state     <= S_IDLE;
        ptr       <= 3'd0;
        step_sel  <= 3'd0;
        round_idx <= '0;
        busy      <= 1'b0;
`ifdef PERMUTE_STEP_TIMEOUT_EN
        error     <= 1'b0;
`endif
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state      <= S_LOAD;
              load_state <= 1'b1;
              busy       <= 1'b1;
            end
          end

          S_LOAD: begin
            state      <= S_ISSUE;
            ptr        <= 3'd0;
            step_sel   <= 3'd0;
            step_start <= onehot(3'd0);
          end

          S_ISSUE: begin
            state <= S_WAIT;
`ifdef PERMUTE_STEP_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end

          S_WAIT: begin
            if (step_done[ptr]) begin
              if (ptr != PTR_IOTA) begin
                state      <= S_ISSUE;
                ptr        <= 3'(ptr + 3'd1);
                step_sel   <= 3'(ptr + 3'd1);
                step_start <= onehot(3'(ptr + 3'd1));
              end else if (round_idx != LAST_ROUND) begin
                state      <= S_ISSUE;
                round_idx  <= RND_W'(round_idx + 1'b1);
                ptr        <= 3'd0;
                step_sel   <= 3'd0;
                step_start <= onehot(3'd0);
              end else begin
                state    <= S_FIN;
                ptr      <= 3'd0;
                step_sel <= 3'd0;
                busy     <= 1'b0;
                done     <= 1'b1;
              end
            end
`ifdef PERMUTE_STEP_TIMEOUT_EN
            else if (wait_cnt == TO_LAST) begin
              state     <= S_ERROR;
              ptr       <= 3'd0;
              step_sel  <= 3'd0;
              round_idx <= '0;
              busy      <= 1'b0;
              error     <= 1'b1;
            end else begin
              wait_cnt <= TO_W'(wait_cnt + 1'b1);
            end
`endif
          end

          // Round index stays visible through the completion pulse.
          S_FIN: begin
            state     <= S_IDLE;
            round_idx <= '0;
          end

`ifdef PERMUTE_STEP_TIMEOUT_EN
          S_ERROR: begin
            if (start) begin
              state      <= S_LOAD;
              load_state <= 1'b1;
              busy       <= 1'b1;
              error      <= 1'b0;
            end
          end
`endif

          default: begin
            state     <= S_IDLE;
            ptr       <= 3'd0;
            step_sel  <= 3'd0;
            round_idx <= '0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_permute_round_sequencer.sv
// ---------------------------------------------------------------------------
// tb_permute_round_sequencer
//
// Scoreboard bench. Each run picks per-step unit latencies, derives the
// expected start/write-back/done timeline from the step-cost rule (a step
// issued at t with latency L writes back at t+L and the next step issues at
// t+L+1), queues it, and a monitor process pops and compares whenever the
// DUT presents step_start, wb_en or done. A step-unit model answers starts.
// ---------------------------------------------------------------------------
module tb_permute_round_sequencer;
  localparam int NR    = 24;
  localparam int RW    = 5;
  localparam int TO    = 8;
  localparam int NSTEP = 5 * NR;
  localparam int NEVER = 1 << 30;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [4:0]    step_done;
  logic [4:0]    step_start;
  logic [2:0]    step_sel;
  logic          load_state;
  logic          wb_en;
  logic [RW-1:0] round_idx;
  logic          busy;
  logic          done;
  logic          error;

  permute_round_sequencer #(
    .NUM_ROUNDS    (NR),
    .RND_W         (RW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .step_done (step_done),
    .step_start(step_start),
    .step_sel  (step_sel),
    .load_state(load_state),
    .wb_en     (wb_en),
    .round_idx (round_idx),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int t;
    int oh;
    int rnd;
    int sel;
  } ev_t;

  ev_t sq[$];
  ev_t wq[$];
  int  dq[$];

  // Expected level windows (inclusive cycle ranges)
  int busy_lo = 1, busy_hi = 0;
  int load_t  = -1;
  int err_lo  = NEVER, err_hi = 0;
  bit mon_en  = 1'b0;

  // Step-unit model state
  int         lat[0:NSTEP-1];
  int         issue_k = 0;
  logic [4:0] cur_bit = 5'd0;
  int         pend_t  = -1;
  bit         noise = 1'b0, held = 1'b0, mute = 1'b0;

  always @(negedge clk) begin
    if (step_start != 5'd0) begin
      cur_bit = step_start;
      pend_t  = cyc + lat[(issue_k < NSTEP) ? issue_k : NSTEP - 1];
      issue_k++;
    end
  end

  initial begin
    logic [4:0] sd;
    step_done = 5'd0;
    forever begin
      @(posedge clk);
      #1;
      if (held) begin
        step_done = 5'h1f;
      end else begin
        sd = noise ? (5'($urandom) & ~cur_bit) : 5'd0;
        if (cyc == pend_t && !(mute && cur_bit == 5'h08)) sd = sd | cur_bit;
        step_done = sd;
      end
    end
  end

  // Monitor
  initial begin
    ev_t e;
    int  d;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("busy", int'(busy), int'(cyc >= busy_lo && cyc <= busy_hi));
        chk("load_state", int'(load_state), int'(cyc == load_t));
        chk("error", int'(error), int'(cyc >= err_lo && cyc <= err_hi));
        if (!(cyc >= busy_lo && cyc <= busy_hi + 1) && !(cyc >= err_lo && cyc <= err_hi))
          chk("round_idx_idle", int'(round_idx), 0);
        if (step_start != 5'd0) begin
          if (sq.size() == 0) chk("unexpected_start", int'(step_start), 0);
          else begin
            e = sq.pop_front();
            chk("start_time", cyc, e.t);
            chk("start_vec", int'(step_start), e.oh);
            chk("start_round", int'(round_idx), e.rnd);
            chk("start_sel", int'(step_sel), e.sel);
          end
        end
        if (wb_en) begin
          if (wq.size() == 0) chk("unexpected_wb_en", int'(wb_en), 0);
          else begin
            e = wq.pop_front();
            chk("wb_time", cyc, e.t);
            chk("wb_sel", int'(step_sel), e.sel);
            chk("wb_round", int'(round_idx), e.rnd);
          end
        end
        if (done) begin
          if (dq.size() == 0) chk("unexpected_done", int'(done), 0);
          else begin
            d = dq.pop_front();
            chk("done_time", cyc, d);
          end
        end
      end
    end
  end

  // One permutation request. Latencies drawn in [lmin,lmax]; optional noise on
  // non-active done bits, done held at 1F, abort at c0+abort_off, a stray start
  // at c0+restart_off, a start in the completion cycle, or chi never answering.
  task automatic run(input int lmin, input int lmax, input bit nz, input bit hd,
                     input int abort_off, input int restart_off, input bit fin_start,
                     input bit mt);
    int  c0, t, d, end_t, abort_t, restart_t, fin_t;
    bit  cut;
    ev_t e;
    @(posedge clk);
    #1;
    c0 = cyc;
    noise   = nz;
    held    = hd;
    mute    = mt;
    issue_k = 0;
    pend_t  = -1;
    for (int k = 0; k < NSTEP; k++) lat[k] = hd ? 1 : int'($urandom_range(lmax, lmin));
    abort_t   = (abort_off > 0) ? c0 + abort_off : NEVER;
    restart_t = (restart_off > 0) ? c0 + restart_off : -1;
    fin_t     = -1;
    if (err_lo <= c0) err_hi = c0;
    load_t  = c0 + 1;
    busy_lo = c0 + 1;
    cut     = 1'b0;
    end_t   = 0;
    t       = c0 + 2;
    for (int k = 0; k < NSTEP; k++) begin
      if (t > abort_t) begin cut = 1'b1; break; end
      e.t = t; e.oh = 1 << (k % 5); e.rnd = k / 5; e.sel = k % 5;
      sq.push_back(e);
      if (mt && k == 3) begin
        // WAIT entered at t+1; the watchdog fires after TO WAIT cycles.
        busy_hi = t + TO;
        err_lo  = t + TO + 1;
        err_hi  = NEVER;
        end_t   = err_lo;
        cut     = 1'b1;
        break;
      end
      d = t + lat[k];
      if (d >= abort_t) begin cut = 1'b1; break; end
      e.t = d;
      wq.push_back(e);
      t = d + 1;
    end
    if (!cut) begin
      dq.push_back(t);
      busy_hi = t - 1;
      end_t   = t;
      if (fin_start) fin_t = t;
    end else if (abort_t != NEVER) begin
      busy_hi = abort_t;
      end_t   = abort_t;
    end
    while (cyc <= end_t + 3) begin
      start = (cyc == c0) || (cyc == restart_t) || (cyc == fin_t);
      abort = (cyc == abort_t);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    abort = 1'b0;
    chk("queues_drained", sq.size() + wq.size() + dq.size(), 0);
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_step_start", int'(step_start), 0);
    chk("rst_step_sel", int'(step_sel), 0);
    chk("rst_load_state", int'(load_state), 0);
    chk("rst_wb_en", int'(wb_en), 0);
    chk("rst_round_idx", int'(round_idx), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_error", int'(error), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    run(1, 1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);   // all units L=1
    run(3, 3, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);   // all units L=3
    run(1, 4, 1'b1, 1'b0, 0, 50, 1'b1, 1'b0);  // random L, noise, stray starts
    run(1, 1, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);   // done held at 1F
    run(1, 1, 1'b0, 1'b0, 29, 0, 1'b0, 1'b0);  // abort coincident with done
    run(1, 2, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);   // normal run after abort
`ifdef PERMUTE_STEP_TIMEOUT_EN
    run(1, 2, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1);   // chi never answers
    run(1, 2, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);   // start from ERROR completes
`endif

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
